phase_shift_scheduler: RTL

Round-robin scheduler that shares one `phase_shift_processor` between several delay requesters. It collects per-PLL phase-step requests, grants one PLL at a time, and presents the period count and PLL select to the processor. It then fires the processor's ready strobe and counts PLL `phasedone` pulses to detect completion or timeout. It sits between the delay-distribution logic and the phase-shift processor / PLL reconfiguration port.

---
 rtl/phase_shift_scheduler_if.sv | 30 +++
 rtl/phase_shift_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/phase_shift_scheduler_if.sv
// phase_shift_scheduler_if
//   Groups the requester, phasedone and processor-side signals of the phase
//   shift scheduler.
//   Parameters: NUM_PLL (requesters), SEL_W (PLL select width).
//   slave  : the scheduler (samples i_*, drives o_*).
//   master : the surrounding logic (drives i_*, samples o_*).
interface phase_shift_scheduler_if #(
  parameter int unsigned NUM_PLL = 2,
  parameter int unsigned SEL_W   = 1
);
  logic [NUM_PLL-1:0]   i_req;
  logic [NUM_PLL*8-1:0] i_periods;
  logic                 i_phasedone;
  logic                 o_ready;
  logic [SEL_W-1:0]     o_pll_to_update;
  logic [7:0]           o_periods_to_process;
  logic                 o_busy;
  logic [NUM_PLL-1:0]   o_done;
  logic [NUM_PLL-1:0]   o_err;

  modport slave (
    input  i_req, i_periods, i_phasedone,
    output o_ready, o_pll_to_update, o_periods_to_process, o_busy, o_done, o_err
  );

  modport master (
    output i_req, i_periods, i_phasedone,
    input  o_ready, o_pll_to_update, o_periods_to_process, o_busy, o_done, o_err
  );
endinterface

// File: rtl/phase_shift_scheduler.sv
// phase_shift_scheduler
//   Round-robin arbiter sharing one phase-shift processor between NUM_PLL
//   requesters. Accumulates per-PLL step counts (8-bit saturating), grants one
//   PLL at a time, strobes o_ready, then counts synchronized active-low
//   phasedone pulses until the granted count is consumed or a wait times out.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset
//   bus      : slave side of phase_shift_scheduler_if
//              i_req/i_periods  per-PLL request strobe and step count
//              i_phasedone      asynchronous PLL phasedone (active-low pulse)
//              o_ready          processor ready strobe (READY_CYCLES long)
//              o_pll_to_update  granted PLL, o_periods_to_process granted count
//              o_busy           high outside IDLE
//              o_done/o_err     one-cycle completion / timeout pulse per PLL
module phase_shift_scheduler #(
  parameter int unsigned NUM_PLL      = 2,
  parameter int unsigned SEL_W        = 1,
  parameter int unsigned READY_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 1023,
  parameter int unsigned SETTLE       = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  phase_shift_scheduler_if.slave bus
);

  localparam int unsigned MAX_RS  = (READY_CYCLES > SETTLE) ? READY_CYCLES : SETTLE;
  localparam int unsigned CNT_MAX = (TIMEOUT > MAX_RS) ? TIMEOUT : MAX_RS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_FINISH,
    S_SETTLE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [7:0]         pend [0:NUM_PLL-1];
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   gidx;
  logic [SEL_W-1:0]   pick;
  logic [SEL_W-1:0]   rr_idx;
  logic               pick_vld;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         rem;
  logic               pd_m;
  logic               pd_s;
  logic               tmo_hit;
  logic               ready_nx;
  logic               busy_nx;
  logic [NUM_PLL-1:0] done_nx;
  logic [NUM_PLL-1:0] err_nx;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Round-robin search starting just after the last granted PLL.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = '0;
    for (int unsigned i = 1; i <= NUM_PLL; i++) begin
      rr_idx = SEL_W'((32'(ptr) + i) % NUM_PLL);
      if (!pick_vld && pend[rr_idx] != 8'd0) begin
        pick     = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Pending counts. The granted PLL is cleared in GRANT, but a request landing
  // in that same cycle replaces the cleared value rather than being lost.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < NUM_PLL; k++) pend[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_PLL; k++) begin
        if (state == S_GRANT && 32'(gidx) == k)
          pend[k] <= bus.i_req[k] ? bus.i_periods[8*k +: 8] : 8'd0;
        else if (bus.i_req[k])
          pend[k] <= sat_add(pend[k], bus.i_periods[8*k +: 8]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pd_m <= 1'b1;
      pd_s <= 1'b1;
    end else begin
      pd_m <= bus.i_phasedone;
      pd_s <= pd_m;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // A real phasedone edge wins over a timeout seen in the same cycle.
  always_comb begin
    next_state = state;
    tmo_hit    = 1'b0;
    unique case (state)
      S_IDLE:      if (pick_vld) next_state = S_GRANT;
      S_GRANT:     next_state = S_ISSUE;
      S_ISSUE:     if (cnt == CNT_W'(READY_CYCLES - 1)) next_state = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!pd_s) next_state = S_WAIT_HIGH;
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          next_state = S_FINISH;
          tmo_hit    = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (pd_s) next_state = (rem == 8'd1) ? S_FINISH : S_WAIT_LOW;
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          next_state = S_FINISH;
          tmo_hit    = 1'b1;
        end
      end
      S_FINISH:    next_state = S_SETTLE;
      S_SETTLE:    if (cnt == CNT_W'(SETTLE - 1)) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    ready_nx = (next_state == S_ISSUE);
    busy_nx  = (next_state != S_IDLE);
    done_nx  = '0;
    err_nx   = '0;
    if (next_state == S_FINISH) begin
      if (tmo_hit) err_nx[gidx]  = 1'b1;
      else         done_nx[gidx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bus.o_ready              <= 1'b0;
      bus.o_pll_to_update      <= '0;
      bus.o_periods_to_process <= '0;
      bus.o_busy               <= 1'b0;
      bus.o_done               <= '0;
      bus.o_err                <= '0;
      cnt                      <= '0;
      rem                      <= '0;
      gidx                     <= '0;
      ptr                      <= SEL_W'(NUM_PLL - 1);
    end else begin
      bus.o_ready <= ready_nx;
      bus.o_busy  <= busy_nx;
      bus.o_done  <= done_nx;
      bus.o_err   <= err_nx;
      // One counter serves ISSUE, both waits and SETTLE; it restarts on every
      // state change, including WAIT_HIGH -> WAIT_LOW.
      cnt <= (next_state != state) ? '0 : cnt + CNT_W'(1);
      if (state == S_IDLE && pick_vld) gidx <= pick;
      if (state == S_GRANT) begin
        bus.o_pll_to_update      <= gidx;
        bus.o_periods_to_process <= pend[gidx];
        rem                      <= pend[gidx];
        ptr                      <= gidx;
      end
      if (state == S_WAIT_HIGH && pd_s) rem <= rem - 8'd1;
    end
  end

endmodule
